// File: rtl/memcore_pkg.sv
// Shared constants for the memristor core: default sizing and mode encoding.
package memcore_pkg;

  localparam int LEVEL_W  = 3;
  localparam int HOLD_CYC = 16;

  localparam logic MODE_READ = 1'b0;
  localparam logic MODE_PROG = 1'b1;

endpackage

// File: rtl/memcore_channel.sv
// One memristor channel: input sync, edge detect, level/hold state and PWM pin drive.
// Optional level port is present when MEMCORE_LEVEL_OUT_EN is defined.
module memcore_channel #(
  parameter int LEVEL_W  = memcore_pkg::LEVEL_W,
  parameter int HOLD_CYC = memcore_pkg::HOLD_CYC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sel,
  input  logic               din,
  input  logic [LEVEL_W-1:0] pwm_cnt,
  output logic               drive_en,
  output logic               drive_val
`ifdef MEMCORE_LEVEL_OUT_EN
  ,
  output logic [LEVEL_W-1:0] level
`endif
);
  import memcore_pkg::MODE_PROG;

  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = {LEVEL_W{1'b1}};
  localparam logic [LEVEL_W-1:0] LEVEL_ZERO = {LEVEL_W{1'b0}};
  localparam logic [HOLD_W-1:0]  HOLD_ZERO  = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYC - 1);
  localparam logic [HOLD_W-1:0]  HOLD_FULL  = HOLD_W'(HOLD_CYC);

  logic               sel_meta_r, sel_s_r, sel_prev_r;
  logic               din_meta_r, din_s_r, din_prev_r;
  logic               rise_r;
  logic [HOLD_W-1:0]  hold_r;
  logic [LEVEL_W-1:0] level_r;
  logic               drive_en_r, drive_val_r;

  logic               prog_s, sel_chg_s, rise_s, clear_s;
  logic [HOLD_W-1:0]  hold_nxt_s;
  logic [LEVEL_W-1:0] level_nxt_s;

  // Next-state for hold counter and level; a clear overrides a same-cycle increment.
  always_comb begin
    prog_s      = (sel_s_r == MODE_PROG);
    sel_chg_s   = (sel_s_r != sel_prev_r);
    rise_s      = din_s_r & ~din_prev_r & prog_s;
    clear_s     = 1'b0;
    hold_nxt_s  = HOLD_ZERO;
    level_nxt_s = level_r;
    if (!prog_s || sel_chg_s || !din_s_r) begin
      hold_nxt_s = HOLD_ZERO;
    end else if (hold_r == HOLD_FULL) begin
      hold_nxt_s = hold_r;
    end else begin
      hold_nxt_s = hold_r + HOLD_W'(1);
      clear_s    = (hold_r == HOLD_LAST);
    end
    if (clear_s) begin
      level_nxt_s = LEVEL_ZERO;
    end else if (rise_r && prog_s && (level_r != LEVEL_MAX)) begin
      level_nxt_s = level_r + LEVEL_W'(1);
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Channel state registers; the pin drive is registered so it lags the PWM compare by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_meta_r  <= 1'b0;
      sel_s_r     <= 1'b0;
      sel_prev_r  <= 1'b0;
      din_meta_r  <= 1'b0;
      din_s_r     <= 1'b0;
      din_prev_r  <= 1'b0;
      rise_r      <= 1'b0;
      hold_r      <= HOLD_ZERO;
      level_r     <= LEVEL_ZERO;
      drive_en_r  <= 1'b0;
      drive_val_r <= 1'b0;
    end else begin
      sel_meta_r  <= sel;
      sel_s_r     <= sel_meta_r;
      sel_prev_r  <= sel_s_r;
      din_meta_r  <= din;
      din_s_r     <= din_meta_r;
      din_prev_r  <= din_s_r;
      rise_r      <= rise_s;
      hold_r      <= hold_nxt_s;
      level_r     <= level_nxt_s;
      drive_en_r  <= ~prog_s & din_s_r;
      drive_val_r <= (pwm_cnt < level_r);
    end
  end

  assign drive_en  = drive_en_r;
  assign drive_val = drive_val_r;
`ifdef MEMCORE_LEVEL_OUT_EN
  assign level     = level_r;
`endif

endmodule

// File: rtl/memristor_core_ctrl.sv
// Three-channel memristor behavioural core: shared PWM counter and tri-state analog pins.
// Define MEMCORE_LEVEL_OUT_EN to expose all channel levels on level_o.
module memristor_core_ctrl #(
  parameter int LEVEL_W  = memcore_pkg::LEVEL_W,
  parameter int HOLD_CYC = memcore_pkg::HOLD_CYC
) (
  input  logic wb_clk_i,
  input  logic wb_rst_ni,
  input  logic SEL1,
  input  logic DIGITALIN1,
  input  logic SEL2,
  input  logic DIGITALIN2,
  input  logic SEL3,
  input  logic DIGITALIN3,
  inout  wire  AIN1,
  inout  wire  AIN2,
  inout  wire  AIN3
`ifdef MEMCORE_LEVEL_OUT_EN
  ,
  output logic [3*LEVEL_W-1:0] level_o
`endif
);

  logic [LEVEL_W-1:0] pwm_cnt_r;
  logic [2:0]         sel_s, din_s, en_s, val_s;
`ifdef MEMCORE_LEVEL_OUT_EN
  logic [LEVEL_W-1:0] level_s [3];
`endif

  assign sel_s = {SEL3, SEL2, SEL1};
  assign din_s = {DIGITALIN3, DIGITALIN2, DIGITALIN1};

  // Free-running PWM counter shared by every channel; wraps naturally at full scale.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      pwm_cnt_r <= {LEVEL_W{1'b0}};
    end else begin
      pwm_cnt_r <= pwm_cnt_r + LEVEL_W'(1);
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_ch
    memcore_channel #(
      .LEVEL_W  (LEVEL_W),
      .HOLD_CYC (HOLD_CYC)
    ) u_ch (
      .clk       (wb_clk_i),
      .rst_n     (wb_rst_ni),
      .sel       (sel_s[i]),
      .din       (din_s[i]),
      .pwm_cnt   (pwm_cnt_r),
      .drive_en  (en_s[i]),
      .drive_val (val_s[i])
`ifdef MEMCORE_LEVEL_OUT_EN
      ,
      .level     (level_s[i])
`endif
    );
  end

  assign AIN1 = en_s[0] ? val_s[0] : 1'bz;
  assign AIN2 = en_s[1] ? val_s[1] : 1'bz;
  assign AIN3 = en_s[2] ? val_s[2] : 1'bz;

`ifdef MEMCORE_LEVEL_OUT_EN
  // Registered snapshot of all levels, channel 1 in the LSBs.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      level_o <= {(3*LEVEL_W){1'b0}};
    end else begin
      level_o <= {level_s[2], level_s[1], level_s[0]};
    end
  end
`endif

endmodule

// File: tb/tb_memristor_core_ctrl.sv
// Directed bench for memristor_core_ctrl; pins are pulled up so high-Z reads as 1.
module tb_memristor_core_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:1] sel;
  logic [3:1] din;
  wire        ain1, ain2, ain3;

  pullup (ain1);
  pullup (ain2);
  pullup (ain3);

  always #5 clk = ~clk;

  memristor_core_ctrl dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .SEL1       (sel[1]),
    .DIGITALIN1 (din[1]),
    .SEL2       (sel[2]),
    .DIGITALIN2 (din[2]),
    .SEL3       (sel[3]),
    .DIGITALIN3 (din[3]),
    .AIN1       (ain1),
    .AIN2       (ain2),
    .AIN3       (ain3)
  );

  typedef struct {
    int ch;
    int pulses;
    int exp_lvl;
  } vec_t;

  vec_t vecs[4];
  int   total = 0;
  int   bad   = 0;

  function automatic int get_ain(input int ch);
    case (ch)
      1:       return int'(ain1);
      2:       return int'(ain2);
      3:       return int'(ain3);
      default: return 0;
    endcase
  endfunction

  function automatic int get_lvl(input int ch);
    case (ch)
      1:       return int'(dut.g_ch[0].u_ch.level_r);
      2:       return int'(dut.g_ch[1].u_ch.level_r);
      3:       return int'(dut.g_ch[2].u_ch.level_r);
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_pulse(input int ch);
    @(negedge clk);
    din[ch] = 1'b1;
    repeat (2) @(negedge clk);
    din[ch] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic program_ch(input int ch, input int n);
    @(negedge clk);
    sel[ch] = 1'b1;
    repeat (4) @(negedge clk);
    repeat (n) drive_pulse(ch);
    repeat (4) @(negedge clk);
  endtask

  // Read mode with din=1 for 8 cycles: count of highs equals the level.
  task automatic measure(input int ch, output int highs);
    @(negedge clk);
    sel[ch] = 1'b0;
    din[ch] = 1'b1;
    repeat (6) @(negedge clk);
    highs = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      highs += get_ain(ch);
    end
    din[ch] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int   h;
    int   zcnt;
    int   nz;
    int   trans;
    logic [15:0] pat;
    logic [2:0]  rnd;

    vecs[0] = '{ch: 1, pulses: 2,  exp_lvl: 3};
    vecs[1] = '{ch: 1, pulses: 10, exp_lvl: 7};
    vecs[2] = '{ch: 2, pulses: 5,  exp_lvl: 5};
    vecs[3] = '{ch: 3, pulses: 3,  exp_lvl: 3};

    // Reset with random inputs
    rst_n = 1'b0;
    rnd   = 3'($urandom_range(0, 7));
    sel   = rnd;
    rnd   = 3'($urandom_range(0, 7));
    din   = rnd;
    wait_edges(2);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("reset_hiz_ch%0d", c), get_ain(c), 1);
      chk($sformatf("reset_lvl_ch%0d", c), get_lvl(c), 0);
    end
    @(negedge clk);
    sel   = 3'b000;
    din   = 3'b000;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // First increment lands on the 4th edge after the pin edge
    @(negedge clk);
    sel[1] = 1'b1;
    repeat (4) @(negedge clk);
    din[1] = 1'b1;
    wait_edges(3);
    chk("inc_edge3", get_lvl(1), 0);
    wait_edges(1);
    chk("inc_edge4", get_lvl(1), 1);
    @(negedge clk);
    din[1] = 1'b0;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      program_ch(vecs[v].ch, vecs[v].pulses);
      chk($sformatf("vec%0d_lvl", v), get_lvl(vecs[v].ch), vecs[v].exp_lvl);
      measure(vecs[v].ch, h);
      chk($sformatf("vec%0d_pwm", v), h, vecs[v].exp_lvl);
    end

    // Hold clear on channel 2 (level 5)
    @(negedge clk);
    sel[2] = 1'b1;
    repeat (4) @(negedge clk);
    din[2] = 1'b1;
    zcnt = 0;
    for (int e = 1; e <= 22; e++) begin
      wait_edges(1);
      zcnt += get_ain(2);
      if (e == 3)  chk("clr_e3", get_lvl(2), 5);
      if (e == 4)  chk("clr_e4", get_lvl(2), 6);
      if (e == 17) chk("clr_e17", get_lvl(2), 6);
      if (e == 18) chk("clr_e18", get_lvl(2), 0);
      if (e == 22) chk("clr_e22", get_lvl(2), 0);
    end
    chk("prog_hiz_ch2", zcnt, 22);
    @(negedge clk);
    din[2] = 1'b0;
    repeat (3) @(negedge clk);
    measure(2, h);
    chk("clr_pwm", h, 0);

    // PWM waveform on channel 3 (level 3)
    @(negedge clk);
    sel[3] = 1'b0;
    din[3] = 1'b1;
    repeat (6) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      pat[k] = get_ain(3)[0];
    end
    chk("pwm_cnt_a", $countones(pat[7:0]), 3);
    chk("pwm_cnt_b", $countones(pat[15:8]), 3);
    chk("pwm_period", int'(pat[7:0]), int'(pat[15:8]));
    trans = 0;
    for (int k = 0; k < 8; k++) begin
      if (pat[k] && !pat[(k + 7) % 8]) trans++;
    end
    chk("pwm_one_run", trans, 1);
    din[3] = 1'b0;
    repeat (4) @(negedge clk);
    zcnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      zcnt += get_ain(3);
    end
    chk("read_off_hiz", zcnt, 8);

    // Read-mode pulses must not change the level
    repeat (5) drive_pulse(3);
    chk("immune_lvl", get_lvl(3), 3);
    measure(3, h);
    chk("immune_pwm", h, 3);

    // Reset in the middle of a hold on channel 1 (level 7)
    @(negedge clk);
    sel[1] = 1'b1;
    repeat (4) @(negedge clk);
    din[1] = 1'b1;
    wait_edges(12);
    chk("hold_at_10", int'(dut.g_ch[0].u_ch.hold_r), 10);
    @(negedge clk);
    rst_n  = 1'b0;
    din[1] = 1'b0;
    wait_edges(2);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("midrst_lvl_ch%0d", c), get_lvl(c), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    nz   = 0;
    zcnt = 0;
    for (int e = 0; e < 25; e++) begin
      wait_edges(1);
      if (get_lvl(1) != 0) nz++;
      zcnt += get_ain(1) + get_ain(2) + get_ain(3);
    end
    chk("post_rst_no_event", nz, 0);
    chk("post_rst_hiz", zcnt, 75);
    for (int c = 1; c <= 3; c++) begin
      measure(c, h);
      chk($sformatf("post_rst_pwm_ch%0d", c), h, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memristor_core_ctrl.md
Name: memristor_core_ctrl

Overview:
- Digital behavioural core for three memristor channels.
- Each channel has a select line and a digital pulse input. The core keeps a quantised conductance level per channel.
- Program mode: pulses raise the level, or a long hold clears it.
- Read mode: the level is presented on the channel's bidirectional analog pin as a PWM waveform.
- Sits directly under the user project wrapper; its inputs come from raw GPIO pins.

Parameters:
- LEVEL_W, 3: width of each channel's conductance level; maximum level is 2^LEVEL_W-1.
- HOLD_CYC, 16: number of consecutive synchronised high cycles of DIGITALINn in program mode that triggers a clear.

Ports:
- wb_clk_i  input  1  system clock; all logic on its rising edge.
- wb_rst_ni  input  1  reset, synchronous, active-low.
- SEL1  input  1  channel 1 mode: 1=program, 0=read. Asynchronous to the clock.
- DIGITALIN1  input  1  channel 1 pulse / read-enable. Asynchronous.
- SEL2, DIGITALIN2  input  1 each  channel 2, same meaning as channel 1.
- SEL3, DIGITALIN3  input  1 each  channel 3, same meaning as channel 1.
- AIN1  inout  1  channel 1 pin: PWM output in read mode, high-Z otherwise.
- AIN2  inout  1  channel 2 pin, same meaning.
- AIN3  inout  1  channel 3 pin, same meaning.

Behaviour:
- One clock and one reset, as stated: wb_clk_i; wb_rst_ni synchronous, active-low.
- While wb_rst_ni=0 at a clock edge, the following are cleared to 0:
  - all levels, hold counters, synchroniser flops and previous-value flops;
  - the PWM counter;
  - all AINn drive enables, so every AINn is high-Z.
- Reset mid-operation aborts any pulse or hold in progress.
- Synchronisers: every SELn and DIGITALINn passes through a two-flop synchroniser, giving s_sel and s_din.
- Edge detect: a per-channel previous flop of s_din. rise = s_din & ~prev.
  - An input edge on the pin produces a rise on the 3rd clock edge; the level updates on the 4th.
- Program mode (s_sel=1):
  - Each rise increments the level by 1, saturating at 2^LEVEL_W-1. A rise at maximum leaves the level unchanged.
  - The hold counter increments every cycle s_din=1, saturating at HOLD_CYC, and resets to 0 when s_din=0.
  - When the hold counter reaches HOLD_CYC, the level clears to 0 exactly once per hold; further held cycles do nothing.
  - If the clear and an increment land in the same cycle, the clear wins.
  - AINn is high-Z throughout program mode.
- Read mode (s_sel=0):
  - The level is frozen; rises are ignored; the hold counter is held at 0.
  - If s_din=1: the AINn enable is 1 and AINn is driven with (pwm_cnt < level), registered, so one cycle of latency.
  - If s_din=0: AINn is high-Z.
  - Level 0 drives constant 0. Level 2^LEVEL_W-1 drives high for all but one cycle per period.
- PWM counter: a single free-running LEVEL_W-bit counter shared by all channels. It wraps from 2^LEVEL_W-1 to 0.
- Mode switch: on any change of s_sel, the hold counter resets to 0. The level is preserved across mode changes. A switch to program mode while s_din=1 does not count as a rise unless prev=0.
- Channels are fully independent; simultaneous activity on all three is legal.
- AINn is never read internally; its input value is ignored.

Optional Feature:
- Macro: MEMCORE_LEVEL_OUT_EN.
- When defined: adds output port level_o, width 3*LEVEL_W.
  - Channel 1 occupies the LSBs, then channel 2, then channel 3 at the MSBs.
  - level_o is registered and equals the current levels; it resets to 0.
- When undefined: the port is absent and the behaviour is otherwise identical.

Decomposition:
- Shared package memcore_pkg holds:
  - the default constants LEVEL_W and HOLD_CYC;
  - the mode encoding localparams MODE_READ=0 and MODE_PROG=1.
- One natural sub-module, memcore_channel, instantiated three times. It contains the synchroniser, edge detect, level, hold counter and pin drive.
- The top level owns the PWM counter and the optional level_o concatenation.

Test Plan:
- Reset: hold wb_rst_ni=0 for 2 cycles with random inputs -> AIN1..3 high-Z; level_o=0.
- Program channel 1: SEL1=1; 3 short DIGITALIN1 pulses, each 2 cycles high and 2 low -> level 3, with each increment 4 cycles after its rising pin edge. Then 10 pulses -> level saturates at 7.
- Clear: channel 2 at level 5; SEL2=1; DIGITALIN2 high for 20 cycles -> level 0 exactly 16 cycles after s_din rises. This hold's own rise gives +1 first (6), then the clear to 0; no further change while held.
- Read PWM: channel 3 at level 3; SEL3=0; DIGITALIN3=1 -> AIN3 high 3 of every 8 cycles, periodic. DIGITALIN3=0 -> high-Z after sync latency.
- Read-mode immunity: SEL1=0 with 5 pulses on DIGITALIN1 -> level unchanged.
- Reset mid-hold: assert wb_rst_ni=0 at hold cycle 10 -> all levels 0; no clear event fires after release.
